seg7_scan_ctrl: RTL and testbench
=================================

# seg7_scan_ctrl

Scan scheduler for the four-digit Basys3 seven-segment display. It time-multiplexes one shared digit decoder across four anodes, inserting a blanking interval between digits to prevent ghosting. It applies per-digit enables, leading-zero suppression and per-digit blinking. Display values load atomically at frame boundaries. It sits between game logic (target and counter values) and the hex-to-segment decoder / pad outputs.

## Interface
Parameters:
- DIV, default 100000: clock cycles per digit slot (1 kHz slot rate at 100 MHz); legal range ≥ 2.
- BLANK, default 1000: cycles at the start of each slot with all anodes off; legal range 1 ≤ BLANK < DIV.
- BLINK_DIV, default 125: frames per blink half-period; legal range ≥ 1.

Ports:
- clk_i  in  1  system clock; all logic is in this one clock domain.
- rst_i  in  1  reset; synchronous and active-high.
- value_i  in  16  four hex digits; [3:0] = digit0 (rightmost) … [15:12] = digit3.
- digit_en_i  in  4  per-digit enable; 0 forces that digit dark.
- blink_mask_i  in  4  per-digit blink select.
- lz_suppress_i  in  1  leading-zero suppression on digits 3..1.
- load_i  in  1  one-cycle strobe; captures value_i, digit_en_i, blink_mask_i and lz_suppress_i into the shadow registers.
- anode_o  out  4  active-low anode drive; at most one bit is low.
- digit_o  out  4  hex digit for the decoder, for the current slot.
- digit_valid_o  out  1  high while an anode is driven.
- slot_o  out  2  index of the current slot.

## Operation
- State machine with two states:
  - BLANK: all anodes high. Lasts BLANK cycles, then goes to DRIVE.
  - DRIVE: anode_o[slot] low if the digit is visible. Lasts DIV−BLANK cycles, then the slot advances and the state returns to BLANK.
- One cycle counter (clog2(DIV) bits) runs from 0 to DIV−1 and wraps to 0 at the slot end.
- Slot order is 0→1→2→3→0. One frame is four slots. The frame boundary is the last cycle of slot 3.
- Register sets:
  - The shadow set is written on any load_i.
  - The active set is copied from the shadow set only at the frame boundary, and only if a load is pending.
  - If load_i is asserted in the boundary cycle, the value_i and control inputs from that cycle go straight to the active set.
  - The pending flag clears at the transfer.
- Visibility of digit k is decided at slot start from the active set. The digit is visible when all three hold:
  - en[k] = 1;
  - it is not blanked by blink (blink_phase = 1 and mask[k] = 1 blanks it);
  - it is not suppressed. Digit k in 1..3 is suppressed when lz = 1 and active digits k..3 are all zero. Digit0 is never suppressed.
- blink_phase toggles every BLINK_DIV frames, at a frame boundary. A frame counter wraps from BLINK_DIV−1 to 0.
- digit_o and slot_o update on the first BLANK cycle of each slot, so the decoder settles during blanking. digit_o holds its value through the slot.
- digit_valid_o = (state == DRIVE) && visible. anode_o = ~(digit_valid_o << slot), registered.

## Timing
- While rst_i is high, at the next edge and after it:
  - anode_o = 4'b1111, digit_o = 0, digit_valid_o = 0, slot_o = 0;
  - state = BLANK, counters = 0;
  - shadow and active registers = 0 (all digits disabled), blink_phase = 0, pending = 0.
- Reset asserted mid-slot aborts the slot. The first post-reset slot is slot 0 with a full BLANK period.
- All outputs are registered. The first cycle after reset release is cycle 0 of slot 0.
- Slot period is exactly DIV cycles; frame period is exactly 4·DIV cycles.
- Anode k is low during cycles BLANK..DIV−1 of slot k. No two anodes are ever low in the same cycle.
- A load appears on the display at slot 0 of the first frame starting after the load. Load-to-display latency is at most 4·DIV+BLANK cycles.
- Multiple loads within one frame: the last one wins.
- In BLANK cycles, digit_valid_o = 0 even when the digit is visible.

## Test plan
Run with DIV=8, BLANK=2, BLINK_DIV=2.
- Reset and idle: rst_i held 3 cycles, then released, no load → anode_o = 4'b1111 and digit_valid_o = 0 for 64 cycles; slot_o steps 0,1,2,3 every 8 cycles.
- Basic scan: load value_i=16'h1234, digit_en_i=4'hF, lz=0, mask=0, then wait for the frame start.
  - Slot 0: digit_o=4, anode_o=4'b1110 in cycles 2–7.
  - Slot 3: digit_o=1, anode_o=4'b0111.
  - Cycles 0–1 of each slot: anode_o=4'b1111.
- Leading zeros: load 16'h0050, lz=1, en=4'hF → digits 3 and 2 dark; digit1 shows 5; digit0 shows 0.
  - Load 16'h0000 → only digit0 lit, showing 0.
- Atomic load: load 16'hAAAA mid-frame, then 16'hBBBB in the boundary cycle → current frame keeps the old value; next frame shows B on all digits; A is never displayed.
- Blink: mask=4'b1000, en=4'hF → digit3 lit for 2 frames, dark for 2 frames, repeating; digits 0–2 always lit.
- Reset mid-DRIVE in slot 2 → next cycle anode_o=4'b1111 and slot_o=0; display stays dark until a new load arrives.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
// Scan scheduler for a four-digit multiplexed seven-segment display.
// One shared decoder is time-multiplexed across four active-low anodes.
// Each slot starts with a blanking interval to avoid ghosting.
// New display values are staged in a shadow set. They move to the active
// set only at a frame boundary, so a frame never mixes old and new digits.
// All outputs are registered. They are driven from the *_next values, so
// each output lines up exactly with the cycle counter.
module seg7_scan_ctrl #(
  parameter int DIV       = 100000,
  parameter int BLANK     = 1000,
  parameter int BLINK_DIV = 125
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] value_i,
  input  logic [3:0]  digit_en_i,
  input  logic [3:0]  blink_mask_i,
  input  logic        lz_suppress_i,
  input  logic        load_i,
  output logic [3:0]  anode_o,
  output logic [3:0]  digit_o,
  output logic        digit_valid_o,
  output logic [1:0]  slot_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CW-1:0] LAST_CNT   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_DIV - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  // scan timing
  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [1:0]    slot_reg, slot_next;
  logic          slot_end;
  logic          frame_end;

  // blink timing
  logic [FW-1:0] frame_reg, frame_next;
  logic          phase_reg, phase_next;

  // shadow register set, written by any load
  logic [15:0]   sh_value_reg;
  logic [3:0]    sh_en_reg;
  logic [3:0]    sh_mask_reg;
  logic          sh_lz_reg;
  logic          pending_reg, pending_next;

  // active register set, seen by the display
  logic [15:0]   act_value_reg, act_value_next;
  logic [3:0]    act_en_reg, act_en_next;
  logic [3:0]    act_mask_reg, act_mask_next;
  logic          act_lz_reg, act_lz_next;

  // per-slot output state
  logic [3:0]    vis_digit;
  logic [3:0]    supp_digit;
  logic          visible_reg, visible_next;
  logic [3:0]    digit_reg, digit_next;
  logic          valid_reg, valid_next;
  logic [3:0]    anode_reg, anode_next;

  assign slot_end  = (cnt_reg == LAST_CNT);
  assign frame_end = slot_end && (slot_reg == 2'd3);

  // Scan state register: blanking/drive phase, cycle-in-slot and slot index.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_BLANK;
      cnt_reg   <= '0;
      slot_reg  <= 2'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      slot_reg  <= slot_next;
    end
  end

  // Scan next state: BLANK for the first BLANK cycles of a slot, then DRIVE to the slot end.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 1'b1;
    slot_next  = slot_reg;
    if (slot_end) begin
      cnt_next  = '0;
      slot_next = slot_reg + 2'd1;
    end
    case (state_reg)
      ST_BLANK: if (cnt_reg == BLANK_LAST) state_next = ST_DRIVE;
      ST_DRIVE: if (slot_end)              state_next = ST_BLANK;
      default:                             state_next = ST_BLANK;
    endcase
  end

  // Register-set transfer and blink phase: both change only at a frame boundary.
  // A load in the boundary cycle itself bypasses the shadow set.
  always_comb begin
    act_value_next = act_value_reg;
    act_en_next    = act_en_reg;
    act_mask_next  = act_mask_reg;
    act_lz_next    = act_lz_reg;
    pending_next   = pending_reg | load_i;
    frame_next     = frame_reg;
    phase_next     = phase_reg;
    if (frame_end) begin
      pending_next = 1'b0;
      if (load_i) begin
        act_value_next = value_i;
        act_en_next    = digit_en_i;
        act_mask_next  = blink_mask_i;
        act_lz_next    = lz_suppress_i;
      end else if (pending_reg) begin
        act_value_next = sh_value_reg;
        act_en_next    = sh_en_reg;
        act_mask_next  = sh_mask_reg;
        act_lz_next    = sh_lz_reg;
      end
      if (frame_reg == FRAME_LAST) begin
        frame_next = '0;
        phase_next = ~phase_reg;
      end else begin
        frame_next = frame_reg + 1'b1;
      end
    end
  end

  // Shadow set capture: the last load in a frame wins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sh_value_reg <= '0;
      sh_en_reg    <= '0;
      sh_mask_reg  <= '0;
      sh_lz_reg    <= 1'b0;
    end else if (load_i) begin
      sh_value_reg <= value_i;
      sh_en_reg    <= digit_en_i;
      sh_mask_reg  <= blink_mask_i;
      sh_lz_reg    <= lz_suppress_i;
    end
  end

  // Active set, pending flag and blink counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      act_value_reg <= '0;
      act_en_reg    <= '0;
      act_mask_reg  <= '0;
      act_lz_reg    <= 1'b0;
      pending_reg   <= 1'b0;
      frame_reg     <= '0;
      phase_reg     <= 1'b0;
    end else begin
      act_value_reg <= act_value_next;
      act_en_reg    <= act_en_next;
      act_mask_reg  <= act_mask_next;
      act_lz_reg    <= act_lz_next;
      pending_reg   <= pending_next;
      frame_reg     <= frame_next;
      phase_reg     <= phase_next;
    end
  end

  // Per-digit visibility, evaluated from the set that is active in the coming cycle.
  // Digit 0 always shows, even when every digit is zero.
  // Digits 1..3 are suppressed when they and every digit above them are zero.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_vis
      if (gi == 0) begin : g_lsd
        assign supp_digit[gi] = 1'b0;
      end else begin : g_upper
        assign supp_digit[gi] = act_lz_next && (act_value_next[15:4*gi] == '0);
      end
      assign vis_digit[gi] = act_en_next[gi]
                           && !(phase_next && act_mask_next[gi])
                           && !supp_digit[gi];
    end
  endgenerate

  // Output next values.
  // Visibility and digit are latched on the first BLANK cycle of a slot,
  // which gives the decoder the whole blanking interval to settle.
  always_comb begin
    visible_next = visible_reg;
    digit_next   = digit_reg;
    if (cnt_next == '0) begin
      visible_next = vis_digit[slot_next];
      digit_next   = act_value_next[{slot_next, 2'b00} +: 4];
    end
    valid_next = (state_next == ST_DRIVE) && visible_next;
    anode_next = ~({3'b000, valid_next} << slot_next);
  end

  // Registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      visible_reg <= 1'b0;
      digit_reg   <= 4'd0;
      valid_reg   <= 1'b0;
      anode_reg   <= 4'b1111;
    end else begin
      visible_reg <= visible_next;
      digit_reg   <= digit_next;
      valid_reg   <= valid_next;
      anode_reg   <= anode_next;
    end
  end

  assign anode_o       = anode_reg;
  assign digit_o       = digit_reg;
  assign digit_valid_o = valid_reg;
  assign slot_o        = slot_reg;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl
// Directed bench for seg7_scan_ctrl with DIV=8, BLANK=2, BLINK_DIV=2.
// A frame-level model recomputes the expected outputs from the absolute cycle
// number since reset and from the list of loads seen in each frame.
// The model's results are checked every cycle.
// Hand-computed literal checks pin the model at chosen cycles.
module tb_seg7_scan_ctrl;

  localparam int DIV       = 8;
  localparam int BLANK     = 2;
  localparam int BLINK_DIV = 2;
  localparam int FRAME     = 4 * DIV;
  localparam int MAXF      = 64;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [15:0] value_i = '0;
  logic [3:0]  digit_en_i = '0;
  logic [3:0]  blink_mask_i = '0;
  logic        lz_suppress_i = 1'b0;
  logic        load_i = 1'b0;
  logic [3:0]  anode_o;
  logic [3:0]  digit_o;
  logic        digit_valid_o;
  logic [1:0]  slot_o;

  int errors = 0;
  int checks = 0;

  // Cycle index since the last reset edge.
  int t = 0;
  bit started = 1'b0;

  // Last load captured in each frame.
  bit          ld_has  [MAXF];
  logic [15:0] ld_val  [MAXF];
  logic [3:0]  ld_en   [MAXF];
  logic [3:0]  ld_mask [MAXF];
  logic        ld_lz   [MAXF];
  int          rec_f;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .DIV(DIV), .BLANK(BLANK), .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .value_i(value_i), .digit_en_i(digit_en_i),
    .blink_mask_i(blink_mask_i), .lz_suppress_i(lz_suppress_i), .load_i(load_i),
    .anode_o(anode_o), .digit_o(digit_o), .digit_valid_o(digit_valid_o), .slot_o(slot_o)
  );

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at t=%0d: got %h expected %h", name, t, got, exp);
    end
  endtask

  // Track the cycle number and record loads by the frame that captured them.
  always @(posedge clk) begin
    if (rst_i) begin
      t <= 0;
      started <= 1'b1;
      for (int i = 0; i < MAXF; i++) ld_has[i] = 1'b0;
    end else begin
      if (load_i) begin
        rec_f = t / FRAME;
        if (rec_f < MAXF) begin
          ld_has[rec_f]  = 1'b1;
          ld_val[rec_f]  = value_i;
          ld_en[rec_f]   = digit_en_i;
          ld_mask[rec_f] = blink_mask_i;
          ld_lz[rec_f]   = lz_suppress_i;
        end
      end
      t <= t + 1;
    end
  end

  // The model shows frame f using the most recent load from any earlier frame.
  int          m_f, m_s, m_c;
  bit          m_found, m_phase, m_vis, m_valid;
  logic [15:0] m_val, m_upper;
  logic [3:0]  m_en, m_mask, m_anode, m_digit;
  logic        m_lz;

  always @(negedge clk) begin
    if (started) begin
      m_f = t / FRAME;
      m_s = (t / DIV) % 4;
      m_c = t % DIV;
      m_found = 1'b0;
      m_val = '0; m_en = '0; m_mask = '0; m_lz = 1'b0;
      for (int g = MAXF - 1; g >= 0; g--) begin
        if (!m_found && g < m_f && ld_has[g]) begin
          m_found = 1'b1;
          m_val = ld_val[g]; m_en = ld_en[g]; m_mask = ld_mask[g]; m_lz = ld_lz[g];
        end
      end
      m_phase = ((m_f / BLINK_DIV) % 2) == 1;
      m_upper = m_val >> (4 * m_s);
      m_digit = 4'(m_upper);
      m_vis   = m_en[m_s] && !(m_phase && m_mask[m_s]) && !(m_lz && m_s > 0 && m_upper == 16'h0);
      m_valid = m_vis && (m_c >= BLANK);
      m_anode = m_valid ? 4'(~(4'b0001 << m_s)) : 4'b1111;
      check("cyc_anode", {12'h0, anode_o}, {12'h0, m_anode});
      check("cyc_digit", {12'h0, digit_o}, {12'h0, m_digit});
      check("cyc_valid", {15'h0, digit_valid_o}, {15'h0, m_valid});
      check("cyc_slot",  {14'h0, slot_o}, 16'(m_s));
      check("cyc_one_anode", 16'($countones(~anode_o) <= 1), 16'h1);
    end
  end

  task automatic goto(input int target);
    int guard = 0;
    while (t < target && guard < 4000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (t != target) begin
      checks++; errors++;
      $display("FAIL goto: t=%0d required %0d", t, target);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] en,
                         input logic [3:0] mask, input logic lz);
    value_i = v; digit_en_i = en; blink_mask_i = mask; lz_suppress_i = lz;
    load_i = 1'b1;
    @(posedge clk); #1;
    load_i = 1'b0;
  endtask

  initial begin
    // reset and idle
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    check("rst_anode", {12'h0, anode_o}, 16'h000F);
    check("rst_digit", {12'h0, digit_o}, 16'h0000);
    check("rst_valid", {15'h0, digit_valid_o}, 16'h0000);
    check("rst_slot",  {14'h0, slot_o}, 16'h0000);
    goto(8);  check("idle_slot1", {14'h0, slot_o}, 16'h0001);
    goto(16); check("idle_slot2", {14'h0, slot_o}, 16'h0002);
    goto(26); check("idle_anode", {12'h0, anode_o}, 16'h000F);
              check("idle_slot3", {14'h0, slot_o}, 16'h0003);

    // basic scan: load in frame 2, shown from frame 3 (t=96)
    goto(64);  do_load(16'h1234, 4'hF, 4'h0, 1'b0);
    goto(96);  check("scan_s0_blank", {12'h0, anode_o}, 16'h000F);
               check("scan_s0_digit_early", {12'h0, digit_o}, 16'h0004);
    goto(98);  check("scan_s0_anode", {12'h0, anode_o}, 16'h000E);
               check("scan_s0_digit", {12'h0, digit_o}, 16'h0004);
    goto(122); check("scan_s3_anode", {12'h0, anode_o}, 16'h0007);
               check("scan_s3_digit", {12'h0, digit_o}, 16'h0001);

    // leading zeros: 0050 shown in frame 5, then 0000 in frame 7
    goto(128); do_load(16'h0050, 4'hF, 4'h0, 1'b1);
    goto(162); check("lz_d0_anode", {12'h0, anode_o}, 16'h000E);
               check("lz_d0_digit", {12'h0, digit_o}, 16'h0000);
    goto(170); check("lz_d1_anode", {12'h0, anode_o}, 16'h000D);
               check("lz_d1_digit", {12'h0, digit_o}, 16'h0005);
    goto(178); check("lz_d2_dark", {12'h0, anode_o}, 16'h000F);
    goto(186); check("lz_d3_dark", {12'h0, anode_o}, 16'h000F);
    goto(192); do_load(16'h0000, 4'hF, 4'h0, 1'b1);
    goto(226); check("lz0_d0_anode", {12'h0, anode_o}, 16'h000E);
    goto(234); check("lz0_d1_dark", {12'h0, anode_o}, 16'h000F);

    // atomic load: AAAA mid frame 8, BBBB in the boundary cycle t=287
    goto(258); check("atom_old_digit", {12'h0, digit_o}, 16'h0000);
    goto(261); do_load(16'hAAAA, 4'hF, 4'h0, 1'b0);
    goto(274); check("atom_old_dark", {12'h0, anode_o}, 16'h000F);
    goto(287); do_load(16'hBBBB, 4'hF, 4'h0, 1'b0);
    goto(290); check("atom_b_s0", {12'h0, digit_o}, 16'h000B);
               check("atom_b_s0_anode", {12'h0, anode_o}, 16'h000E);
    goto(314); check("atom_b_s3", {12'h0, digit_o}, 16'h000B);

    // blink on digit 3, active from frame 11
    goto(320); do_load(16'h1234, 4'hF, 4'b1000, 1'b0);
    goto(378); check("blink_f11_dark", {12'h0, anode_o}, 16'h000F);
    goto(410); check("blink_f12_lit", {12'h0, anode_o}, 16'h0007);
               check("blink_f12_digit", {12'h0, digit_o}, 16'h0001);
    goto(442); check("blink_f13_lit", {12'h0, anode_o}, 16'h0007);
    goto(450); check("blink_f14_d0", {12'h0, anode_o}, 16'h000E);
    goto(474); check("blink_f14_dark", {12'h0, anode_o}, 16'h000F);

    // reset during DRIVE of slot 2
    goto(500); check("pre_rst_anode", {12'h0, anode_o}, 16'h000B);
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    check("mid_rst_anode", {12'h0, anode_o}, 16'h000F);
    check("mid_rst_slot",  {14'h0, slot_o}, 16'h0000);
    goto(18);  check("post_rst_dark", {12'h0, anode_o}, 16'h000F);
    goto(64);  do_load(16'h00A7, 4'b0011, 4'h0, 1'b0);
    goto(98);  check("new_d0", {12'h0, digit_o}, 16'h0007);
               check("new_d0_anode", {12'h0, anode_o}, 16'h000E);
    goto(106); check("new_d1", {12'h0, digit_o}, 16'h000A);
               check("new_d1_anode", {12'h0, anode_o}, 16'h000D);
    goto(114); check("new_d2_disabled", {12'h0, anode_o}, 16'h000F);
    goto(130);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
